window_timer: RTL and testbench

- Measurement-window controller for the ring-oscillator PUF counter bank.
- A start request loads a window length W. The block then drives one clear pulse to the edge counters, followed by exactly W cycles of count-enable.
- It then signals done so downstream compare logic can sample the counter values.
- It counts down where the edge counters count up, and it drives their clr/up inputs.

---
 rtl/puf_pkg.sv | 13 +
 rtl/down_counter.sv | 36 +++
 rtl/window_timer.sv | 108 ++++++++++
 tb/tb_window_timer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// Shared types and defaults for the ring-oscillator PUF measurement logic.
package puf_pkg;

  localparam int unsigned WIN_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } win_state_t;

endpackage

// File: rtl/down_counter.sv
// Loadable down counter that saturates at zero; zero flag is registered alongside cnt.
module down_counter #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         dec,
  output logic [N-1:0] cnt,
  output logic         zero
);

  logic [N-1:0] cnt_next;

  // Priority: load over dec; a dec at zero holds the count.
  always_comb begin
    cnt_next = cnt;
    if (load) begin
      cnt_next = load_val;
    end else if (dec && (cnt != '0)) begin
      cnt_next = cnt - N'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      zero <= 1'b1;
    end else begin
      cnt  <= cnt_next;
      zero <= (cnt_next == '0);
    end
  end

endmodule

// File: rtl/window_timer.sv
// Measurement-window controller: one clear pulse, then W count-enable cycles, then done.
// Optional abort port pair is enabled by defining WINDOW_TIMER_ABORT_EN.
module window_timer
  import puf_pkg::*;
#(
  parameter int unsigned N = WIN_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] window,
  output logic         busy,
  output logic         cnt_clr,
  output logic         cnt_up,
  output logic         done,
  output logic [N-1:0] remaining,
  output logic         zero
`ifdef WINDOW_TIMER_ABORT_EN
  ,
  input  logic         abort,
  output logic         aborted
`endif
);

  win_state_t state;
  win_state_t state_next;
  logic       load;
  logic       dec;
  logic       abort_hit;
  logic       busy_next;
  logic       cnt_clr_next;
  logic       cnt_up_next;
  logic       done_next;

`ifdef WINDOW_TIMER_ABORT_EN
  assign abort_hit = abort && ((state == CLEAR) || (state == RUN));
`else
  assign abort_hit = 1'b0;
`endif

  down_counter #(.N(N)) u_remaining (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (window),
    .dec      (dec),
    .cnt      (remaining),
    .zero     (zero)
  );

  // Next-state logic; output strobes are decoded from the next state and registered.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    dec        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = CLEAR;
          load       = 1'b1;
        end
      end
      CLEAR: begin
        if (abort_hit)  state_next = IDLE;
        else if (zero)  state_next = DONE;
        else            state_next = RUN;
      end
      RUN: begin
        if (abort_hit) begin
          state_next = IDLE;
        end else begin
          dec = 1'b1;
          if (remaining == N'(1)) state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    busy_next    = (state_next == CLEAR) || (state_next == RUN);
    cnt_clr_next = (state_next == CLEAR);
    cnt_up_next  = (state_next == RUN);
    done_next    = (state_next == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      cnt_clr <= 1'b0;
      cnt_up  <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      busy    <= busy_next;
      cnt_clr <= cnt_clr_next;
      cnt_up  <= cnt_up_next;
      done    <= done_next;
    end
  end

`ifdef WINDOW_TIMER_ABORT_EN
  always_ff @(posedge clk) begin
    if (rst) aborted <= 1'b0;
    else     aborted <= abort_hit;
  end
`endif

endmodule

// File: tb/tb_window_timer.sv
// Directed self-checking bench for window_timer (abort checks when WINDOW_TIMER_ABORT_EN is defined).
module tb_window_timer;

  localparam int unsigned N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] window;
  logic         busy;
  logic         cnt_clr;
  logic         cnt_up;
  logic         done;
  logic [N-1:0] remaining;
  logic         zero;
`ifdef WINDOW_TIMER_ABORT_EN
  logic         abort;
  logic         aborted;
`endif

  int n_cmp = 0;
  int n_err = 0;

  window_timer #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .window    (window),
    .busy      (busy),
    .cnt_clr   (cnt_clr),
    .cnt_up    (cnt_up),
    .done      (done),
    .remaining (remaining),
    .zero      (zero)
`ifdef WINDOW_TIMER_ABORT_EN
    ,
    .abort     (abort),
    .aborted   (aborted)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; outputs are then stable for the new cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packed view of strobes: {cnt_clr, cnt_up, done, busy}.
  function automatic logic [31:0] strobes();
    return {28'd0, cnt_clr, cnt_up, done, busy};
  endfunction

  int ups, dones, clrs;
  logic [3:0] pat [5];

  initial begin
    rst = 1'b1; start = 1'b0; window = '0;
`ifdef WINDOW_TIMER_ABORT_EN
    abort = 1'b0;
`endif
    tick(); tick();
    check("rst_strobes", strobes(), 32'h0);
    check("rst_remaining", remaining, 32'd0);
    check("rst_zero", 32'(zero), 32'd1);
    rst = 1'b0;
    tick();

    // Nominal window of 5
    start = 1'b1; window = 32'd5;
    tick();
    start = 1'b0; window = 32'd99;
    check("nom_clear", strobes(), 32'b1001);
    check("nom_clear_rem", remaining, 32'd5);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("nom_run", strobes(), 32'b0101);
      check("nom_run_rem", remaining, 32'(5 - i));
    end
    tick();
    check("nom_done", strobes(), 32'b0010);
    check("nom_done_rem", remaining, 32'd0);
    check("nom_done_zero", 32'(zero), 32'd1);
    tick();
    check("nom_idle", strobes(), 32'b0000);

    // Zero-length window
    start = 1'b1; window = 32'd0;
    tick();
    start = 1'b0;
    check("w0_clear", strobes(), 32'b1001);
    check("w0_zero", 32'(zero), 32'd1);
    tick();
    check("w0_done", strobes(), 32'b0010);
    tick();
    check("w0_idle", strobes(), 32'b0000);

    // start and window changes during RUN are ignored
    start = 1'b1; window = 32'd10;
    tick();
    start = 1'b0;
    check("ign_clear", strobes(), 32'b1001);
    ups = 0; dones = 0; clrs = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 2) begin start = 1'b1; window = 32'd3; end
      if (i == 3) start = 1'b0;
      tick();
      ups   += int'(cnt_up);
      dones += int'(done);
      clrs  += int'(cnt_clr);
    end
    check("ign_ups", 32'(ups), 32'd10);
    check("ign_dones", 32'(dones), 32'd1);
    check("ign_clrs", 32'(clrs), 32'd0);
    check("ign_rem", remaining, 32'd0);

    // Back-to-back runs with start held high, window of 2
    pat[0] = 4'b1001; pat[1] = 4'b0101; pat[2] = 4'b0101; pat[3] = 4'b0010; pat[4] = 4'b0000;
    start = 1'b1; window = 32'd2;
    for (int j = 0; j < 15; j++) begin
      if (j == 14) start = 1'b0;
      tick();
      check($sformatf("b2b_c%0d", j), strobes(), 32'(pat[j % 5]));
    end
    tick();
    check("b2b_stop", strobes(), 32'b0000);

    // start arriving during DONE is not queued
    start = 1'b1; window = 32'd1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("dq_done", strobes(), 32'b0010);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("dq_idle", strobes(), 32'b0000);
    tick();
    check("dq_still_idle", strobes(), 32'b0000);

    // Reset on the 3rd count-enable cycle of window 8
    start = 1'b1; window = 32'd8;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("mid_run3", strobes(), 32'b0101);
    check("mid_run3_rem", remaining, 32'd6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst", strobes(), 32'b0000);
    check("mid_rst_rem", remaining, 32'd0);
    check("mid_rst_zero", 32'(zero), 32'd1);
    tick();
    check("mid_no_done", strobes(), 32'b0000);

    // Largest window: count starts at all-ones and decrements without wrap
    start = 1'b1; window = 32'hFFFF_FFFF;
    tick();
    start = 1'b0;
    check("max_clear_rem", remaining, 32'hFFFF_FFFF);
    tick();
    check("max_run_rem0", remaining, 32'hFFFF_FFFF);
    tick();
    check("max_run_rem1", remaining, 32'hFFFF_FFFE);
    check("max_run_zero", 32'(zero), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("max_rst", strobes(), 32'b0000);

`ifdef WINDOW_TIMER_ABORT_EN
    // Abort on the 4th RUN cycle of window 6
    start = 1'b1; window = 32'd6;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    check("ab_run4_rem", remaining, 32'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_aborted", 32'(aborted), 32'd1);
    check("ab_strobes", strobes(), 32'b0000);
    check("ab_rem", remaining, 32'd3);
    tick();
    check("ab_pulse_end", 32'(aborted), 32'd0);
    check("ab_no_done", strobes(), 32'b0000);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_idle_ignored", 32'(aborted), 32'd0);
    // rst beats abort
    start = 1'b1; window = 32'd4;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1; rst = 1'b1;
    tick();
    abort = 1'b0; rst = 1'b0;
    check("ab_rst_wins", 32'(aborted), 32'd0);
    check("ab_rst_rem", remaining, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
